// File: rtl/serial_alu_ctrl.sv
// ============================================================================
// Module   : serial_alu_ctrl
// Purpose  : Bit-serial ALU sequencer. One 1-bit cell (full adder plus
//            AND/OR/NAND/NOR/NOT/PASS logic) processes one operand bit per
//            clock, LSB first, under a start/ready/done handshake.
//
// Ports    : clk        rising-edge clock
//            reset      asynchronous active-high reset
//            start      operation request, sampled only while ready=1
//            op[2:0]    opcode, captured with start
//            a, b       WIDTH-bit operands, captured with start
//            ready      high in IDLE
//            busy       high in RUN
//            done       one-cycle pulse when result is valid
//            result     WIDTH-bit result, held until next accepted start
//            carry_out  final carry for ADD/SUB (1 = no borrow for SUB)
//            zero       (SERIAL_ALU_FLAGS_EN only) result == 0
//            overflow   (SERIAL_ALU_FLAGS_EN only) signed overflow, ADD/SUB
//
// Options  : define SERIAL_ALU_FLAGS_EN to add the zero/overflow outputs.
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu_ctrl #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             overflow
`endif
);

    // State encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Opcodes
    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_NAND = 3'b100;
    localparam logic [2:0] c_OP_NOR  = 3'b101;
    localparam logic [2:0] c_OP_NOT  = 3'b110;
    localparam logic [2:0] c_OP_PASS = 3'b111;

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_idx;
    logic             r_carry;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_carry_out;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             r_zero;
    logic             r_overflow;
`endif

    logic             w_is_sub;
    logic             w_is_arith;
    logic             w_bit_a;
    logic             w_bit_b;
    logic             w_sum;
    logic             w_cout;
    logic             w_res_bit;
    logic [WIDTH-1:0] w_result_next;

    // The 1-bit cell. Operand registers shift right each cycle so bit 0 is
    // always the bit under processing; SUB feeds the adder with inverted b.
    always_comb begin
        w_is_sub   = (r_op == c_OP_SUB);
        w_is_arith = (r_op == c_OP_ADD) || (r_op == c_OP_SUB);
        w_bit_a    = r_a[0];
        w_bit_b    = r_b[0] ^ w_is_sub;
        w_sum      = w_bit_a ^ w_bit_b ^ r_carry;
        w_cout     = (w_bit_a & w_bit_b) | (w_bit_a & r_carry) | (w_bit_b & r_carry);
        w_res_bit  = 1'b0;
        case (r_op)
            c_OP_ADD,
            c_OP_SUB:  w_res_bit = w_sum;
            c_OP_AND:  w_res_bit = w_bit_a & r_b[0];
            c_OP_OR:   w_res_bit = w_bit_a | r_b[0];
            c_OP_NAND: w_res_bit = ~(w_bit_a & r_b[0]);
            c_OP_NOR:  w_res_bit = ~(w_bit_a | r_b[0]);
            c_OP_NOT:  w_res_bit = ~w_bit_a;
            c_OP_PASS: w_res_bit = w_bit_a;
            default:   w_res_bit = 1'b0;
        endcase
        // Result bits enter at the MSB; after WIDTH shifts the first-processed
        // bit lands in bit 0, so no variable-index write is needed.
        w_result_next = {w_res_bit, r_result[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_op        <= c_OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_carry_out <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state     <= c_RUN;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_op        <= op;
                        r_a         <= a;
                        r_b         <= b;
                        r_result    <= '0;
                        r_idx       <= '0;
                        // Carry seed of 1 with inverted b gives a + ~b + 1.
                        r_carry     <= (op == c_OP_SUB);
                        r_carry_out <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
                        r_zero      <= 1'b0;
                        r_overflow  <= 1'b0;
`endif
                    end
                end

                c_RUN: begin
                    r_a      <= {1'b0, r_a[WIDTH-1:1]};
                    r_b      <= {1'b0, r_b[WIDTH-1:1]};
                    r_result <= w_result_next;
                    r_idx    <= r_idx + CNT_W'(1);
                    if (w_is_arith) begin
                        r_carry <= w_cout;
                    end
                    if (r_idx == c_LAST_IDX) begin
                        r_state     <= c_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_carry_out <= w_is_arith & w_cout;
`ifdef SERIAL_ALU_FLAGS_EN
                        r_zero      <= ~|w_result_next;
                        // r_carry here is the carry into the MSB.
                        r_overflow  <= w_is_arith & (r_carry ^ w_cout);
`endif
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= c_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
`ifdef SERIAL_ALU_FLAGS_EN
    assign zero      = r_zero;
    assign overflow  = r_overflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
// ============================================================================
// Module   : tb_serial_alu_ctrl
// Purpose  : Self-checking bench for serial_alu_ctrl. The driver pushes the
//            hand-computed expected response when an operation is accepted;
//            the monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_alu_ctrl;

    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             zero;
    logic             overflow;
`endif

    serial_alu_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
`ifdef SERIAL_ALU_FLAGS_EN
        ,
        .zero      (zero),
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cy;
        logic             zf;
        logic             ovf;
        bit               chk_flags;
        int               acc_cyc;
        string            name;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit               hold_chk = 1'b0;
    logic [WIDTH-1:0] held_res;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (hold_chk) begin
                check("hold_result", 32'(result), 32'(held_res));
                check("ready_after_done", 32'(ready), 32'd1);
            end
            hold_chk = 1'b0;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, 32'(result), 32'(e.res));
                    check({e.name, "_carry"}, 32'(carry_out), 32'(e.cy));
                    check({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'(WIDTH));
`ifdef SERIAL_ALU_FLAGS_EN
                    if (e.chk_flags) begin
                        check({e.name, "_zero"}, 32'(zero), 32'(e.zf));
                        check({e.name, "_overflow"}, 32'(overflow), 32'(e.ovf));
                    end
`endif
                    held_res = result;
                    hold_chk = 1'b1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] er, input logic ec, input string nm,
                            input logic ez, input logic ev, input bit cf);
        exp_t e;
        e.res = er; e.cy = ec; e.zf = ez; e.ovf = ev; e.chk_flags = cf;
        e.acc_cyc = cyc; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input logic [WIDTH-1:0] er, input logic ec, input string nm,
                         input bit do_push = 1'b1, input logic ez = 1'b0,
                         input logic ev = 1'b0, input bit cf = 1'b0);
        wait_ready();
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk);
        #1;
        if (do_push) push_exp(er, ec, nm, ez, ev, cf);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int n;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_carry", 32'(carry_out), 32'd0);
        reset = 1'b0;

        // ADD 3+5 with busy-length check
        issue(3'b000, 3'd3, 3'd5, 3'd0, 1'b1, "add_3_5");
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) break;
        end
        check("add_busy_cycles", 32'(nb), 32'd3);

        issue(3'b001, 3'd5, 3'd3, 3'd2, 1'b1, "sub_5_3");
        issue(3'b001, 3'd3, 3'd5, 3'd6, 1'b0, "sub_3_5");
        issue(3'b100, 3'd6, 3'd3, 3'd5, 1'b0, "nand_6_3");
        issue(3'b110, 3'd2, 3'd0, 3'd5, 1'b0, "not_2");
        issue(3'b111, 3'd7, 3'd5, 3'd7, 1'b0, "pass_7");
        issue(3'b101, 3'd1, 3'd2, 3'd4, 1'b0, "nor_1_2");
        issue(3'b010, 3'd6, 3'd3, 3'd2, 1'b0, "and_6_3");
        issue(3'b011, 3'd5, 3'd2, 3'd7, 1'b0, "or_5_2");
        issue(3'b000, 3'd7, 3'd1, 3'd0, 1'b1, "add_7_1");

        // start held high during RUN/DONE: ignored until ready
        wait_ready();
        start = 1'b1; op = 3'b000; a = 3'd1; b = 3'd1;
        @(posedge clk);
        #1;
        push_exp(3'd2, 1'b0, "b2b_first", 1'b0, 1'b0, 1'b0);
        a = 3'd7; b = 3'd7;
        wait_ready();
        @(posedge clk);
        #1;
        push_exp(3'd6, 1'b1, "b2b_second", 1'b0, 1'b0, 1'b0);
        start = 1'b0;

        // reset during the second RUN cycle of ADD 7+7
        issue(3'b000, 3'd7, 3'd7, 3'd0, 1'b0, "add_aborted", 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_ready", 32'(ready), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_result", 32'(result), 32'd0);
        check("midreset_carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("post_reset_ready", 32'(ready), 32'd1);
        issue(3'b000, 3'd2, 3'd2, 3'd4, 1'b0, "add_2_2");

`ifdef SERIAL_ALU_FLAGS_EN
        issue(3'b000, 3'd3, 3'd1, 3'd4, 1'b0, "flags_add_3_1", 1'b1, 1'b0, 1'b1, 1'b1);
        issue(3'b001, 3'd4, 3'd4, 3'd0, 1'b1, "flags_sub_4_4", 1'b1, 1'b1, 1'b0, 1'b1);
        issue(3'b010, 3'd4, 3'd3, 3'd0, 1'b0, "flags_and_4_3", 1'b1, 1'b1, 1'b0, 1'b1);
`endif

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
Bit-serial sequencer that computes WIDTH-bit ALU operations with one 1-bit cell: a full-adder slice plus single-bit AND/OR/NAND/NOR/NOT/pass logic. It is the area-minimal alternative to the parallel 3-bit ALU. It processes one bit per clock, LSB first, under a start/ready/done handshake, and holds the result until the next operation is accepted. It sits between the instruction decode logic and the register file.

Parameters:
WIDTH, 3, operand and result width in bits (>=2).
CNT_W, 2, bit-index counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; sampled only when ready=1.
op  input  3  opcode, captured with start.
a  input  WIDTH  operand A, captured with start.
b  input  WIDTH  operand B, captured with start.
ready  output  1  high in IDLE; start is accepted only while high.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse when result is valid.
result  output  WIDTH  operation result; held until the next accepted start.
carry_out  output  1  final carry for ADD/SUB; 0 for logic ops.

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE, bit index=0, internal carry=0, operand shift registers=0. Outputs: ready=1, busy=0, done=0, result=0, carry_out=0.
- States and transitions:
  - IDLE: if start=1, go to RUN.
  - RUN: stay in RUN while index<WIDTH-1. When index=WIDTH-1, go to DONE.
  - DONE: always go to IDLE after one cycle.
- Start acceptance (at the edge where IDLE and start=1):
  - Latch op, a, b.
  - Clear result to 0.
  - Set index=0.
  - Set carry=1 for SUB, else carry=0.
  - Start asserted in RUN or DONE is ignored and not queued.
- RUN, one bit per cycle. Bit i of the latched operands drives the cell and result[i] is written:
  - 000 ADD: a^b^c; new carry = majority(a, b, c).
  - 001 SUB: same as ADD with b inverted; the carry seed of 1 gives two's-complement a-b.
  - 010 AND: a&b.
  - 011 OR: a|b.
  - 100 NAND: ~(a&b).
  - 101 NOR: ~(a|b).
  - 110 NOT: ~a (b ignored).
  - 111 PASS: a (b ignored).
  - The carry register updates only for ADD/SUB.
- Latency: start accepted at edge k; bits are processed at edges k+1 through k+WIDTH.
  - At edge k+WIDTH, done, carry_out and the full result are registered.
  - done is high for exactly the one cycle following edge k+WIDTH (state DONE).
  - ready returns high one cycle later.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- carry_out:
  - Updated only at completion and held until the next start is accepted, at which point it clears to 0.
  - For SUB, carry_out=1 means no borrow (a>=b unsigned).
- Arithmetic is modulo 2^WIDTH. Overflow beyond WIDTH is visible only through carry_out.
- result is stable and valid from the done cycle until the next accepted start. Intermediate bits are not guaranteed valid while busy=1.
- Operand inputs may change freely after acceptance without affecting the operation.

Optional Feature:
Macro: SERIAL_ALU_FLAGS_EN.
- Defined: adds two outputs, zero (1 bit) and overflow (1 bit), registered alongside done and held exactly like carry_out.
  - zero=1 when result==0, for all ops.
  - overflow = carry into MSB XOR carry out of MSB, for ADD/SUB only; 0 for logic ops.
  - Both reset to 0 and clear when a new start is accepted.
- Not defined: the ports and logic are absent; the remaining behaviour is unchanged.

Test Plan:
- Reset, then ADD a=3, b=5, start for 1 cycle -> done exactly 3 cycles after acceptance, result=0, carry_out=1, busy high for 3 cycles.
- SUB a=5, b=3 -> result=2, carry_out=1; then SUB a=3, b=5 -> result=6, carry_out=0.
- NAND a=6, b=3 -> result=5, carry_out=0; NOT a=2 -> result=5; PASS a=7 -> result=7; NOR a=1, b=2 -> result=4.
- ADD a=1, b=1 accepted, then start with a=7, b=7 held high during RUN and DONE -> the second request is ignored until ready; first result=2. The second operation is accepted on the first ready cycle and yields result=6, carry_out=1.
- Assert reset during the second RUN cycle of ADD 7+7 -> immediately ready=1, busy=0, done=0, result=0, carry_out=0; no done pulse follows. A subsequent ADD 2+2 gives result=4.
- With SERIAL_ALU_FLAGS_EN: ADD 3+1 -> result=4, overflow=1, zero=0; SUB 4-4 -> result=0, zero=1, overflow=0, carry_out=1.
